pipe_datapath_fwd: RTL

Parametrised successor to the fixed 32-bit pipelined MIPS datapath. Holds the ID/EX/MEM/WB stage registers, register file and ALU, and adds three things the previous generation lacked: an internal forwarding unit, load-use stall detection and per-stage valid bits with flush. It sits between the instruction fetch unit (instruction plus decoded controls in, sign-extended immediate and jr operand out) and an external single-port data memory.

---
 rtl/pipe_dp_pkg.sv | 42 ++++
 rtl/pipe_datapath_fwd_fwd.sv | 51 +++++
 rtl/pipe_datapath_fwd.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_dp_pkg.sv
// Shared types and constants for the forwarding pipelined datapath.
// Instruction field offsets, ALU op encoding, control bundle and forward-source select.
package pipe_dp_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_e;

   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;

   typedef struct packed {
      logic    reg_wr;
      logic    reg_dst;
      logic    mem_wr;
      logic    mem_to_reg;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   // Bit i set when register i is a real, writable register (reg 0 and i >= n excluded).
   function automatic logic [31:0] reg_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 1; i < 32; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pipe_datapath_fwd_fwd.sv
// Forward-source selection for the ID-stage operands and load-use hazard detection.
// Purely combinational; the top muxes the actual values.
module fwd_unit
   import pipe_dp_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_valid,
   input  logic       ex_reg_wr,
   input  logic       ex_mem_to_reg,
   input  logic [4:0] ex_dest,
   input  logic       mem_valid,
   input  logic       mem_reg_wr,
   input  logic [4:0] mem_dest,
   input  logic       wb_valid,
   input  logic       wb_reg_wr,
   input  logic [4:0] wb_dest,
   output logic [1:0] rs_sel,
   output logic [1:0] rt_sel,
   output logic       load_use
);

   localparam logic [31:0] REG_MASK = reg_mask(NREGS);

   // Nearest producer wins; a load still in EX has no data yet and is left to the stall.
   function automatic fwd_sel_e pick(input logic [4:0] src);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (REG_MASK[src]) begin
         if (ex_valid && ex_reg_wr && !ex_mem_to_reg && ex_dest == src)
            sel = FWD_EX;
         else if (mem_valid && mem_reg_wr && mem_dest == src)
            sel = FWD_MEM;
         else if (wb_valid && wb_reg_wr && wb_dest == src)
            sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      rs_sel = pick(id_rs);
      rt_sel = pick(id_rt);
   end

   assign load_use = id_valid && ex_valid && ex_mem_to_reg && (ex_dest != 5'd0) &&
                     ((ex_dest == id_rs) || (ex_dest == id_rt));

endmodule

// File: rtl/pipe_datapath_fwd.sv
// Pipelined MIPS-style datapath (ID/EX/MEM/WB) with forwarding, load-use stall and flush.
// Optional build macro PERF_CNT_EN enables the saturating load-use stall counter.
module pipe_datapath_fwd
   import pipe_dp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instr,
   input  logic             reg_dst,
   input  logic             reg_wr,
   input  logic             alu_src,
   input  logic [1:0]       alu_op,
   input  logic             mem_wr,
   input  logic             mem_to_reg,
   input  logic             flush,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic             dmem_we,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic [WIDTH-1:0] se_out,
   output logic [WIDTH-1:0] jr_data,
   output logic             wb_valid,
   output logic [4:0]       wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic [31:0]      stall_count
);

   localparam logic [31:0] REG_MASK = reg_mask(NREGS);

   // IF/ID
   logic             fd_valid;
   logic [25:0]      fd_instr;
   ctrl_t            fd_ctrl;
   // ID/EX
   logic             de_valid;
   ctrl_t            de_ctrl;
   logic [4:0]       de_dest;
   logic [WIDTH-1:0] de_a;
   logic [WIDTH-1:0] de_b;
   logic [WIDTH-1:0] de_imm;
   // EX/MEM
   logic             em_valid;
   ctrl_t            em_ctrl;
   logic [4:0]       em_dest;
   logic [WIDTH-1:0] em_alu;
   logic [WIDTH-1:0] em_wdata;
   // MEM/WB
   logic             mw_valid;
   logic             mw_reg_wr;
   logic [4:0]       mw_dest;
   logic [WIDTH-1:0] mw_data;

   logic [WIDTH-1:0] rf [NREGS];

   ctrl_t            in_ctrl;
   logic [4:0]       id_rs, id_rt, id_dest;
   logic [WIDTH-1:0] id_imm, id_a, id_b;
   logic [WIDTH-1:0] ex_b, ex_alu, mem_val;
   logic [1:0]       rs_sel, rt_sel;
   logic             load_use, stall;
   logic             unused_bits;

   assign in_ctrl = '{reg_wr: reg_wr, reg_dst: reg_dst, mem_wr: mem_wr,
                      mem_to_reg: mem_to_reg, alu_src: alu_src, alu_op: alu_op_e'(alu_op)};

   assign id_rs   = fd_instr[RS_LSB +: 5];
   assign id_rt   = fd_instr[RT_LSB +: 5];
   assign id_dest = fd_ctrl.reg_dst ? fd_instr[RD_LSB +: 5] : id_rt;
   assign id_imm  = WIDTH'($signed(fd_instr[15:0]));

   fwd_unit #(.NREGS(NREGS)) u_fwd (
      .id_valid      (fd_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .ex_valid      (de_valid),
      .ex_reg_wr     (de_ctrl.reg_wr),
      .ex_mem_to_reg (de_ctrl.mem_to_reg),
      .ex_dest       (de_dest),
      .mem_valid     (em_valid),
      .mem_reg_wr    (em_ctrl.reg_wr),
      .mem_dest      (em_dest),
      .wb_valid      (mw_valid),
      .wb_reg_wr     (mw_reg_wr),
      .wb_dest       (mw_dest),
      .rs_sel        (rs_sel),
      .rt_sel        (rt_sel),
      .load_use      (load_use)
   );

   // A flush kills the ID instruction, so there is nothing left to stall for.
   assign stall       = load_use && !flush;
   assign instr_ready = !rst && !stall;

   always_comb begin
      ex_b   = de_ctrl.alu_src ? de_imm : de_b;
      ex_alu = de_a + ex_b;
      case (de_ctrl.alu_op)
         ALU_ADD: ex_alu = de_a + ex_b;
         ALU_SUB: ex_alu = de_a - ex_b;
         ALU_AND: ex_alu = de_a & ex_b;
         ALU_OR:  ex_alu = de_a | ex_b;
         default: ex_alu = de_a + ex_b;
      endcase
   end

   assign mem_val = em_ctrl.mem_to_reg ? dmem_rdata : em_alu;

   // The WB forward is also the write-first path: MEM/WB is written into rf at the next edge.
   function automatic logic [WIDTH-1:0] operand(input logic [1:0] sel, input logic [4:0] src);
      logic [WIDTH-1:0] v;
      case (fwd_sel_e'(sel))
         FWD_EX:  v = ex_alu;
         FWD_MEM: v = mem_val;
         FWD_WB:  v = mw_data;
         default: v = REG_MASK[src] ? rf[src] : '0;
      endcase
      return v;
   endfunction

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      id_a = operand(rs_sel, id_rs);
      id_b = operand(rt_sel, id_rt);
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fd_valid  <= 1'b0;
         fd_instr  <= '0;
         fd_ctrl   <= '0;
         de_valid  <= 1'b0;
         de_ctrl   <= '0;
         de_dest   <= '0;
         de_a      <= '0;
         de_b      <= '0;
         de_imm    <= '0;
         em_valid  <= 1'b0;
         em_ctrl   <= '0;
         em_dest   <= '0;
         em_alu    <= '0;
         em_wdata  <= '0;
         mw_valid  <= 1'b0;
         mw_reg_wr <= 1'b0;
         mw_dest   <= '0;
         mw_data   <= '0;
         // NOTE: the register file is architecturally cleared by reset, so it is built from resettable flops.
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         if (!stall) begin
            fd_instr <= instr[25:0];
            fd_ctrl  <= in_ctrl;
         end
         fd_valid <= flush ? 1'b0 : (stall ? fd_valid : instr_valid);

         de_valid <= fd_valid && !flush && !stall;
         de_ctrl  <= fd_ctrl;
         de_dest  <= id_dest;
         de_a     <= id_a;
         de_b     <= id_b;
         de_imm   <= id_imm;

         em_valid <= de_valid;
         em_ctrl  <= de_ctrl;
         em_dest  <= de_dest;
         em_alu   <= ex_alu;
         em_wdata <= de_b;

         mw_valid  <= em_valid;
         mw_reg_wr <= em_ctrl.reg_wr;
         mw_dest   <= em_dest;
         mw_data   <= mem_val;

         if (mw_valid && mw_reg_wr && REG_MASK[mw_dest]) rf[mw_dest] <= mw_data;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = '0;
`endif

   assign dmem_addr  = em_alu;
   assign dmem_wdata = em_wdata;
   assign dmem_we    = !rst && em_valid && em_ctrl.mem_wr;
   assign se_out     = de_imm;
   assign jr_data    = de_a;
   assign wb_valid   = !rst && mw_valid && mw_reg_wr;
   assign wb_addr    = mw_dest;
   assign wb_data    = mw_data;

   // Opcode and controls that have no meaning past MEM are carried but never read.
   assign unused_bits = ^{instr[31:26], em_ctrl.reg_dst, em_ctrl.alu_src, em_ctrl.alu_op};

endmodule
